// File: rtl/sr_latch_arbiter_if.sv
// +----------------------------------------------------------------------+
// | sr_latch_arbiter_if                                                  |
// | Requester/latch-side signal bundle for sr_latch_arbiter.             |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface sr_latch_arbiter_if;
  logic req_a;
  logic op_a;
  logic req_b;
  logic op_b;
  logic q;
  logic s;
  logic r;
  logic done_a;
  logic done_b;
  logic busy;
  logic err;

  modport master (
    output req_a, op_a, req_b, op_b, q,
    input  s, r, done_a, done_b, busy, err
  );

  modport slave (
    input  req_a, op_a, req_b, op_b, q,
    output s, r, done_a, done_b, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/sr_latch_arbiter.sv
// +----------------------------------------------------------------------+
// | sr_latch_arbiter                                                     |
// | Round-robin arbiter sharing one SR latch between requesters A and B, |
// | issuing fixed-width s/r pulses with a recovery gap between them.     |
// | Optional read-back check enabled by SR_LATCH_ARBITER_VERIFY_EN.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module sr_latch_arbiter #(
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic                clk,
  input  logic                rst,
  sr_latch_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    CHECK = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_gnt;   // 0 = A, 1 = B
  logic       r_op;
  logic       r_last;
  logic       r_s;
  logic       r_r;
  logic       r_done_a;
  logic       r_done_b;
  logic       w_win;
  logic       w_win_op;

`ifdef SR_LATCH_ARBITER_VERIFY_EN
  logic       r_err;
`endif

  // On a tie the requester that did not win last time takes the grant.
  always_comb begin
    w_win    = (bus.req_a && bus.req_b) ? ~r_last : bus.req_b;
    w_win_op = w_win ? bus.op_b : bus.op_a;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 8'd0;
      r_gnt    <= 1'b0;
      r_op     <= 1'b0;
      r_last   <= 1'b1;
      r_s      <= 1'b0;
      r_r      <= 1'b0;
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
`ifdef SR_LATCH_ARBITER_VERIFY_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
      case (r_state)
        IDLE: begin
          r_s <= 1'b0;
          r_r <= 1'b0;
          if (bus.req_a || bus.req_b) begin
            r_gnt   <= w_win;
            r_last  <= w_win;
            r_op    <= w_win_op;
            r_s     <= w_win_op;
            r_r     <= ~w_win_op;
            r_cnt   <= 8'(PULSE_CYC - 1);
            r_state <= PULSE;
          end
        end
        PULSE: begin
          if (r_cnt == 8'd0) begin
            r_s <= 1'b0;
            r_r <= 1'b0;
`ifdef SR_LATCH_ARBITER_VERIFY_EN
            r_state  <= CHECK;
`else
            r_state  <= GAP;
            r_cnt    <= 8'(GAP_CYC - 1);
            r_done_a <= ~r_gnt;
            r_done_b <= r_gnt;
`endif
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        CHECK: begin
          r_s <= 1'b0;
          r_r <= 1'b0;
`ifdef SR_LATCH_ARBITER_VERIFY_EN
          if (bus.q != r_op)
            r_err <= 1'b1;
          r_state  <= GAP;
          r_cnt    <= 8'(GAP_CYC - 1);
          r_done_a <= ~r_gnt;
          r_done_b <= r_gnt;
`else
          r_state  <= IDLE;
`endif
        end
        GAP: begin
          r_s <= 1'b0;
          r_r <= 1'b0;
          if (r_cnt == 8'd0)
            r_state <= IDLE;
          else
            r_cnt <= r_cnt - 8'd1;
        end
        default: begin
          r_s     <= 1'b0;
          r_r     <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.s      = r_s;
  assign bus.r      = r_r;
  assign bus.done_a = r_done_a;
  assign bus.done_b = r_done_b;
  assign bus.busy   = (r_state != IDLE);

`ifdef SR_LATCH_ARBITER_VERIFY_EN
  assign bus.err = r_err;
`else
  // Read-back is not used without the check state.
  logic unused_q;
  assign unused_q = bus.q;
  assign bus.err  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_sr_latch_arbiter                                                  |
// | Directed self-checking bench for sr_latch_arbiter with a latch model.|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sr_latch_arbiter;
  localparam int P = 2;
  localparam int G = 1;
`ifdef SR_LATCH_ARBITER_VERIFY_EN
  localparam int EX = 1;
`else
  localparam int EX = 0;
`endif
  // Cycles from one grant to the next when both requesters stay busy.
  localparam int L = P + G + 1 + EX;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic q_l = 1'b0;
  logic force_q0 = 1'b0;
  logic both_seen = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [63:0] s_log, r_log, da_log, db_log, busy_log;

  sr_latch_arbiter_if bus();

  assign bus.q = force_q0 ? 1'b0 : q_l;

  sr_latch_arbiter #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.s)      q_l <= 1'b1;
    else if (bus.r) q_l <= 1'b0;
  end

  always @(negedge clk) begin
    if (bus.s === 1'b1 && bus.r === 1'b1) both_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  // Log outputs for cycles T+1..T+ncyc; requests drop on their done unless held.
  task automatic run(input int ncyc, input bit hold);
    s_log = '0; r_log = '0; da_log = '0; db_log = '0; busy_log = '0;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      s_log[k]    = bus.s;
      r_log[k]    = bus.r;
      da_log[k]   = bus.done_a;
      db_log[k]   = bus.done_b;
      busy_log[k] = bus.busy;
      if (!hold) begin
        if (bus.done_a) bus.req_a = 1'b0;
        if (bus.done_b) bus.req_b = 1'b0;
      end
    end
  endtask

  initial begin
    bus.req_a = 1'b0;
    bus.op_a  = 1'b0;
    bus.req_b = 1'b0;
    bus.op_b  = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_s",      64'(bus.s),      64'd0);
    chk("rst_r",      64'(bus.r),      64'd0);
    chk("rst_done_a", 64'(bus.done_a), 64'd0);
    chk("rst_done_b", 64'(bus.done_b), 64'd0);
    chk("rst_busy",   64'(bus.busy),   64'd0);
    chk("rst_err",    64'(bus.err),    64'd0);
    rst = 1'b0;
    tick();

    // Single set from A
    bus.req_a = 1'b1; bus.op_a = 1'b1;
    run(8, 1'b0);
    chk("set_s",      s_log,    64'h6);
    chk("set_r",      r_log,    64'h0);
    chk("set_done_a", da_log,   64'd1 << (3 + EX));
    chk("set_done_b", db_log,   64'h0);
    chk("set_busy",   busy_log, (64'd1 << (4 + EX)) - 64'd2);
    chk("set_q",      64'(bus.q),   64'd1);
    chk("set_err",    64'(bus.err), 64'd0);

    // Tie after reset: A (set) first, then B (reset)
    do_reset();
    bus.req_a = 1'b1; bus.op_a = 1'b1;
    bus.req_b = 1'b1; bus.op_b = 1'b0;
    run(12, 1'b0);
    chk("tie_s",      s_log,  64'h6);
    chk("tie_r",      r_log,  64'h3 << (5 + EX));
    chk("tie_done_a", da_log, 64'd1 << (3 + EX));
    chk("tie_done_b", db_log, 64'd1 << (7 + 2 * EX));
    chk("tie_q",      64'(bus.q), 64'd0);

    // Fairness: both held for four operations
    do_reset();
    bus.req_a = 1'b1; bus.op_a = 1'b1;
    bus.req_b = 1'b1; bus.op_b = 1'b0;
    run(4 * L - 1, 1'b1);
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    chk("fair_s",      s_log,  (64'h3 << 1) | (64'h3 << (1 + 2 * L)));
    chk("fair_r",      r_log,  (64'h3 << (1 + L)) | (64'h3 << (1 + 3 * L)));
    chk("fair_done_a", da_log, (64'd1 << (3 + EX)) | (64'd1 << (3 + EX + 2 * L)));
    chk("fair_done_b", db_log, (64'd1 << (3 + EX + L)) | (64'd1 << (3 + EX + 3 * L)));
    run(6, 1'b0);
    chk("fair_idle_busy", busy_log, 64'h0);
    chk("fair_idle_s",    s_log,    64'h0);

    // Read-back failure: q held low during a set
    do_reset();
    force_q0 = 1'b1;
    bus.req_a = 1'b1; bus.op_a = 1'b1;
    run(8, 1'b0);
    chk("vfail_done_a", da_log, 64'd1 << (3 + EX));
    chk("vfail_err",    64'(bus.err), 64'(EX));
    repeat (5) tick();
    chk("vfail_err_sticky", 64'(bus.err), 64'(EX));
    force_q0 = 1'b0;
    do_reset();
    chk("vfail_err_cleared", 64'(bus.err), 64'd0);

    // Reset in the first pulse cycle
    bus.req_a = 1'b1; bus.op_a = 1'b1;
    tick();
    chk("mid_s_before",    64'(bus.s),    64'd1);
    chk("mid_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1; bus.req_a = 1'b0;
    tick();
    chk("mid_s_after",    64'(bus.s),    64'd0);
    chk("mid_busy_after", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    run(6, 1'b0);
    chk("mid_no_done", da_log, 64'h0);
    chk("mid_no_s",    s_log,  64'h0);

    chk("s_r_exclusive", 64'(both_seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sr_latch_arbiter.md
# sr_latch_arbiter

Synchronous controller that shares one SR latch between two requesters (A and B), each asking to set or reset it. It serialises requests with round-robin arbitration and drives the latch `s`/`r` inputs with fixed-width pulses. It guarantees `s` and `r` are never high together and enforces a recovery gap between operations. The block sits between the requester logic and the existing `sr_latch`, and reads back `q` for optional verification.

## Interface
- `PULSE_CYC`, default 2: cycles `s` or `r` is held high per operation; legal range 1–255.
- `GAP_CYC`, default 1: idle cycles (`s=r=0`) after each operation before the next grant; legal range 1–255.
- `clk` input 1: clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_a` input 1: requester A request; held high until `done_a`.
- `op_a` input 1: A's operation, 1 = set, 0 = reset; stable while `req_a` is high.
- `req_b` input 1: requester B request.
- `op_b` input 1: B's operation.
- `q` input 1: latch output, read back for verification.
- `s` output 1: latch set drive, registered.
- `r` output 1: latch reset drive, registered.
- `done_a` output 1: one-cycle pulse when A's operation completes.
- `done_b` output 1: one-cycle pulse when B's operation completes.
- `busy` output 1: high in every state except IDLE.
- `err` output 1: sticky verification-failure flag.

## Operation
- **States**: IDLE, PULSE, CHECK, GAP.
- **IDLE**:
  - If any `req_x` is high, grant one requester and latch `gnt` and `op_g`.
  - Load the counter with `PULSE_CYC-1` and go to PULSE.
  - Otherwise stay in IDLE.
- **Arbitration**: round-robin on a 1-bit `last` pointer.
  - Single request: that requester wins.
  - Both requesting: the requester not equal to `last` wins.
  - `last` updates on each grant.
  - After reset `last`=B, so A wins the first tie.
- **PULSE**:
  - `s = op_g`, `r = ~op_g`; the counter decrements.
  - At count 0 go to CHECK (macro on) or GAP (macro off).
- **CHECK** (one cycle):
  - `s=r=0`.
  - If `q != op_g`, set `err`.
  - Go to GAP.
- **GAP**:
  - `s=r=0`.
  - `done_<gnt>` pulses in the first GAP cycle only.
  - Stay `GAP_CYC` cycles, then return to IDLE.
- **Committed grants**: once granted, an operation always runs to completion and `done` still pulses, even if `req` drops early.
- **`req` after `done`**: a `req` still high in the IDLE cycle after `done` counts as a new request.
- **Invariant**: `s & r` is never 1 in any cycle, including reset and illegal state encodings. Unused encodings return to IDLE with `s=r=0`.
- **Reset values**:
  - `rst` has priority in every state, including mid-PULSE.
  - State = IDLE; `s=r=0`; `done_a=done_b=0`; `busy=0`; `err=0`; `last`=B; counter = 0.
  - A pulse interrupted by reset is dropped and no `done` is issued.
- **`err`**: cleared only by `rst`.

## Timing
- Request first seen high in IDLE at cycle T; grant registered at edge T→T+1.
- `s` or `r` is high in cycles T+1 … T+PULSE_CYC.
- **Macro on**:
  - CHECK occurs at T+PULSE_CYC+1.
  - `done` is high at T+PULSE_CYC+2.
  - IDLE is reached at T+PULSE_CYC+GAP_CYC+2.
- **Macro off**:
  - `done` is high at T+PULSE_CYC+1.
  - IDLE is reached at T+PULSE_CYC+GAP_CYC+1.
- Back-to-back requests: the next pulse starts one cycle after returning to IDLE.
- `busy` goes high at T+1 and low in the first IDLE cycle.

## Configuration
- **`SR_LATCH_ARBITER_VERIFY_EN` defined**: CHECK state present; `q` is compared to the granted op; `err` is live.
- **Not defined**:
  - CHECK state is removed, so every operation is one cycle shorter.
  - `err` is tied to 0 and `q` is unused.

## Test plan
- **Reset**: hold `rst` 3 cycles → `s=r=0`, `done_a=done_b=0`, `busy=0`, `err=0`.
- **Single set**:
  - Stimulus: `req_a=1`, `op_a=1`, PULSE_CYC=2, GAP_CYC=1, with `sr_latch` in loop.
  - Response: `s` high exactly 2 cycles; `q`=1; `done_a` pulses at T+4 (macro on); `err`=0; next IDLE at T+5.
- **Tie**:
  - Stimulus: `req_a` and `req_b` rise together, `op_a=1`, `op_b=0`.
  - Response: A serviced first (`s` pulse), then B (`r` pulse); final `q`=0.
  - Response: `done_a` before `done_b`; `s&r` never 1.
- **Fairness**: hold both `req` high for 4 operations → grants alternate A, B, A, B.
- **Verify fail**: force `q`=0 during a set op (macro on) → `err` rises after CHECK and stays high until `rst`.
- **Mid-pulse reset**: assert `rst` in the first PULSE cycle → next cycle `s=0`, state IDLE, no `done` pulse.
